// File: rtl/czioport_if.sv
// Core-side I/O strobe bus plus the TX/RX byte streams of the czioport peripheral.
// master = core and stream endpoints, slave = the czioport responder.
interface czioport_if;
  logic [7:0] xPORTID_P;
  logic [7:0] xOUTDATA_P;
  logic       xWSTROBE_P;
  logic       xWSTROBEK_P;
  logic       xRSTROBE_P;
  logic [7:0] xINDATA_P;
  logic       xINT0_P;
  logic       xINT1_P;
  logic [7:0] xTXDATA_P;
  logic       xTXVALID_P;
  logic       xTXREADY_P;
  logic [7:0] xRXDATA_P;
  logic       xRXVALID_P;
  logic       xRXREADY_P;

  modport master (
    output xPORTID_P, xOUTDATA_P, xWSTROBE_P, xWSTROBEK_P, xRSTROBE_P,
    output xTXREADY_P, xRXDATA_P, xRXVALID_P,
    input  xINDATA_P, xINT0_P, xINT1_P, xTXDATA_P, xTXVALID_P, xRXREADY_P
  );

  modport slave (
    input  xPORTID_P, xOUTDATA_P, xWSTROBE_P, xWSTROBEK_P, xRSTROBE_P,
    input  xTXREADY_P, xRXDATA_P, xRXVALID_P,
    output xINDATA_P, xINT0_P, xINT1_P, xTXDATA_P, xTXVALID_P, xRXREADY_P
  );
endinterface

// File: rtl/czioport.sv
// czioport: strobe-decoded register file with TX/RX byte FIFOs, an interval
// timer and two level interrupts (RX data available, timer expiry).
module czioport #(
  parameter int FIFO_AW = 3,
  parameter int PRESC   = 16
) (
  input logic       CLK,
  input logic       xRESETN_P,
  czioport_if.slave io
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

  logic [7:0]       tx_mem_q [DEPTH];
  logic [7:0]       rx_mem_q [DEPTH];
  logic [FIFO_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [FIFO_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [1:0]       ien_q, ien_d;
  logic             pend0_q, pend0_d, pend1_q, pend1_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             int0_q, int0_d, int1_q, int1_d;
  logic [7:0]       reload_q, reload_d, cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;

  logic       wr_stb;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       ovf_set, udf_set, tmr_exp;
  logic [3:0] pend_clr;
  logic [7:0] status, rd_mux;

  // Stream handshakes: a byte moves on a rising CLK edge exactly when valid
  // and ready are both high in the preceding cycle; valid never waits on ready.
  always_comb begin
    wr_stb   = io.xWSTROBE_P | io.xWSTROBEK_P;
    tx_empty = (tx_wr_q == tx_rd_q);
    tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
               (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
    rx_empty = (rx_wr_q == rx_rd_q);
    rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
               (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);

    tx_push  = wr_stb && (io.xPORTID_P == 8'h00) && !tx_full;
    ovf_set  = wr_stb && (io.xPORTID_P == 8'h00) && tx_full;
    tx_pop   = !tx_empty && io.xTXREADY_P;
    rx_pop   = io.xRSTROBE_P && (io.xPORTID_P == 8'h00) && !rx_empty;
    udf_set  = io.xRSTROBE_P && (io.xPORTID_P == 8'h00) && rx_empty;
    rx_push  = io.xRXVALID_P && !rx_full;
    pend_clr = (wr_stb && (io.xPORTID_P == 8'h03)) ? io.xOUTDATA_P[3:0] : 4'h0;

    tx_wr_d = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
    tx_rd_d = tx_pop  ? tx_rd_q + 1'b1 : tx_rd_q;
    rx_wr_d = rx_push ? rx_wr_q + 1'b1 : rx_wr_q;
    rx_rd_d = rx_pop  ? rx_rd_q + 1'b1 : rx_rd_q;

    ien_d = (wr_stb && (io.xPORTID_P == 8'h02)) ? io.xOUTDATA_P[1:0] : ien_q;
  end

  // Interval timer: writing RELOAD restarts the period; RELOAD=0 parks it.
  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    tmr_exp  = 1'b0;
    if (wr_stb && (io.xPORTID_P == 8'h04)) begin
      reload_d = io.xOUTDATA_P;
      cnt_d    = io.xOUTDATA_P;
      presc_d  = '0;
    end else if (reload_q != 8'h00) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (cnt_q <= 8'd1) begin
          cnt_d   = reload_q;
          tmr_exp = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Event sources beat same-cycle write-1-to-clear.
  always_comb begin
    pend0_d = !rx_empty | (pend0_q & ~pend_clr[0]);
    pend1_d = tmr_exp   | (pend1_q & ~pend_clr[1]);
    ovf_d   = ovf_set   | (ovf_q   & ~pend_clr[2]);
    udf_d   = udf_set   | (udf_q   & ~pend_clr[3]);
    int0_d  = pend0_q & ien_q[0];
    int1_d  = pend1_q & ien_q[1];
  end

  always_comb begin
    status = {2'b00, udf_q, ovf_q, rx_full, rx_empty, tx_full, tx_empty};
    case (io.xPORTID_P)
      8'h00:   rd_mux = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[FIFO_AW-1:0]];
      8'h01:   rd_mux = status;
      8'h02:   rd_mux = {6'b0, ien_q};
      8'h03:   rd_mux = {6'b0, pend1_q, pend0_q};
      8'h04:   rd_mux = reload_q;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge xRESETN_P) begin
    if (!xRESETN_P) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      ien_q    <= 2'b00;
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      int0_q   <= 1'b0;
      int1_q   <= 1'b0;
      reload_q <= 8'h00;
      cnt_q    <= 8'h00;
      presc_q  <= '0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      ien_q    <= ien_d;
      pend0_q  <= pend0_d;
      pend1_q  <= pend1_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      int0_q   <= int0_d;
      int1_q   <= int1_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem_q[tx_wr_q[FIFO_AW-1:0]] <= io.xOUTDATA_P;
    if (rx_push) rx_mem_q[rx_wr_q[FIFO_AW-1:0]] <= io.xRXDATA_P;
  end

  assign io.xINDATA_P  = xRESETN_P ? rd_mux : 8'h00;
  assign io.xINT0_P    = int0_q;
  assign io.xINT1_P    = int1_q;
  assign io.xTXVALID_P = !tx_empty;
  assign io.xTXDATA_P  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q[FIFO_AW-1:0]];
  assign io.xRXREADY_P = !rx_full;
endmodule

// File: tb/tb_czioport.sv
// Bench for czioport: directed scenarios plus a random phase, all responses
// predicted by a queue-based model and checked by a negedge monitor.
module tb_czioport;
  localparam int PRESC = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  czioport_if io ();
  czioport #(.FIFO_AW(3), .PRESC(PRESC)) dut (.CLK(clk), .xRESETN_P(rst_n), .io(io));

  // reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] ien_m;
  logic       pend0_m, pend1_m, ovf_m, udf_m;
  logic [7:0] reload_m;
  int         load_edge, edge_now;
  logic       int0_nxt, int1_nxt, int0_vis, int1_vis;
  int         txs_mon, rxs_mon;
  logic       mon_en, peek, peek_now, txr;
  int         checks, failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete(); rx_q.delete(); exp_q.delete();
    ien_m = 2'b00; pend0_m = 0; pend1_m = 0; ovf_m = 0; udf_m = 0;
    reload_m = 8'h00; load_edge = 0;
    int0_nxt = 0; int1_nxt = 0; int0_vis = 0; int1_vis = 0;
  endtask

  task automatic idle_inputs();
    io.xWSTROBE_P = 0; io.xWSTROBEK_P = 0; io.xRSTROBE_P = 0;
    io.xPORTID_P = 8'h01; io.xOUTDATA_P = 8'h00;
    io.xRXVALID_P = 0; io.xRXDATA_P = 8'h00; io.xTXREADY_P = 0;
  endtask

  // One clock cycle of stimulus; the model advances by the same cycle.
  task automatic step(input logic wr, input logic wk, input logic rd, input logic [7:0] port,
                      input logic [7:0] wdata, input logic rxv, input logic [7:0] rxd);
    int txs, rxs, upc;
    logic [7:0] rexp, st;
    logic exp1, ovf_set, udf_set;
    logic [3:0] clr;
    @(posedge clk); #1;
    edge_now++;
    upc = edge_now + 1;
    io.xWSTROBE_P = wr; io.xWSTROBEK_P = wk; io.xRSTROBE_P = rd;
    io.xPORTID_P = port; io.xOUTDATA_P = wdata;
    io.xRXVALID_P = rxv; io.xRXDATA_P = rxd; io.xTXREADY_P = txr;
    txs = tx_q.size(); rxs = rx_q.size();
    txs_mon = txs; rxs_mon = rxs;
    int0_vis = int0_nxt; int1_vis = int1_nxt;
    int0_nxt = pend0_m & ien_m[0]; int1_nxt = pend1_m & ien_m[1];
    peek_now = peek;
    ovf_set = 0; udf_set = 0; clr = 4'h0;
    st = {2'b00, udf_m, ovf_m, rxs == DEPTH, rxs == 0, txs == DEPTH, txs == 0};
    if (rd || peek) begin
      case (port)
        8'h00:   rexp = (rxs > 0) ? rx_q[0] : 8'h00;
        8'h01:   rexp = st;
        8'h02:   rexp = {6'b0, ien_m};
        8'h03:   rexp = {6'b0, pend1_m, pend0_m};
        8'h04:   rexp = reload_m;
        default: rexp = 8'h00;
      endcase
      exp_q.push_back(rexp);
    end
    if (rd && port == 8'h00 && rxs == 0) udf_set = 1;
    exp1 = (reload_m != 0) && (upc > load_edge) &&
           (((upc - load_edge) % (int'(reload_m) * PRESC)) == 0);
    if (wr || wk) begin
      case (port)
        8'h00: if (txs < DEPTH) tx_q.push_back(wdata); else ovf_set = 1;
        8'h02: ien_m = wdata[1:0];
        8'h03: clr = wdata[3:0];
        8'h04: begin reload_m = wdata; load_edge = upc; exp1 = 0; end
        default: ;
      endcase
    end
    if (rd && port == 8'h00 && rxs > 0) void'(rx_q.pop_front());
    if (rxv && rxs < DEPTH) rx_q.push_back(rxd);
    pend0_m = (rxs > 0) | (pend0_m & ~clr[0]);
    pend1_m = exp1 | (pend1_m & ~clr[1]);
    ovf_m   = ovf_set | (ovf_m & ~clr[2]);
    udf_m   = udf_set | (udf_m & ~clr[3]);
    mon_en = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 8'h01, 8'h00, 0, 8'h00);
  endtask
  task automatic wr_port(input logic [7:0] port, input logic [7:0] d);
    step(1, 0, 0, port, d, 0, 8'h00);
  endtask
  task automatic rd_port(input logic [7:0] port);
    step(0, 0, 1, port, 8'h00, 0, 8'h00);
  endtask
  task automatic rx_push(input logic [7:0] d);
    step(0, 0, 0, 8'h01, 8'h00, 1, d);
  endtask

  // monitor: compares every DUT presentation against the model's expectations
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("txvalid", io.xTXVALID_P, txs_mon > 0);
      chk("rxready", io.xRXREADY_P, rxs_mon < DEPTH);
      chk("int0", io.xINT0_P, int0_vis);
      chk("int1", io.xINT1_P, int1_vis);
      if (io.xRSTROBE_P || peek_now) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL indata: got 0x%0h with no expectation queued", io.xINDATA_P);
        end else chk("indata", io.xINDATA_P, exp_q.pop_front());
      end
      if (io.xTXVALID_P && io.xTXREADY_P) begin
        if (tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL txdata: got 0x%0h with no byte expected", io.xTXDATA_P);
        end else chk("txdata", io.xTXDATA_P, tx_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, load_e, p, op;
    checks = 0; failures = 0; edge_now = 0;
    mon_en = 0; peek = 0; peek_now = 0; txr = 0;
    model_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;

    // reset mid-transfer
    for (int i = 0; i < 3; i++) wr_port(8'h00, 8'(8'h40 + i));
    @(posedge clk); #1;
    mon_en = 0;
    idle_inputs();
    chk("txvalid_before_reset", io.xTXVALID_P, 1);
    #2 rst_n = 0;
    #1;
    chk("txvalid_async_reset", io.xTXVALID_P, 0);
    chk("rxready_in_reset", io.xRXREADY_P, 1);
    chk("indata_in_reset", io.xINDATA_P, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    model_reset();
    rd_port(8'h01);

    // TX fill and overflow, then drain
    txr = 0;
    for (int i = 0; i < 9; i++) wr_port(8'h00, 8'(8'h10 + i));
    rd_port(8'h01);
    txr = 1;
    idle(12);
    chk("tx_all_emitted", tx_q.size(), 0);
    rd_port(8'h01);
    wr_port(8'h03, 8'h04);
    rd_port(8'h01);

    // RX path and INT0
    wr_port(8'h02, 8'h01);
    rx_push(8'hA5);
    p = edge_now + 1;
    rx_push(8'h5A);
    rise = -1;
    for (int i = 0; i < 10 && rise < 0; i++) begin
      idle(1);
      if (io.xINT0_P === 1'b1) rise = edge_now;
    end
    chk("int0_latency", rise - p, 2);
    rd_port(8'h00);
    rd_port(8'h00);
    wr_port(8'h03, 8'h01);
    idle(3);
    chk("int0_cleared", io.xINT0_P, 0);
    rd_port(8'h00);
    rd_port(8'h01);

    // RX full backpressure, simultaneous pop and push, drain
    for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h01, 8'h00, 1, 8'(8'h30 + i));
    chk("rx_full_ready", io.xRXREADY_P, 0);
    rd_port(8'h01);
    step(0, 0, 1, 8'h00, 8'h00, 1, 8'h99);
    rd_port(8'h01);
    for (int i = 0; i < 8; i++) rd_port(8'h00);
    wr_port(8'h03, 8'h0B);

    // timer and INT1
    wr_port(8'h02, 8'h02);
    wr_port(8'h04, 8'h03);
    load_e = edge_now + 1;
    rise = -1;
    for (int i = 0; i < 80 && rise < 0; i++) begin
      idle(1);
      if (io.xINT1_P === 1'b1) rise = edge_now;
    end
    chk("int1_latency", rise - load_e, 49);
    while (edge_now + 2 < load_e + 96) idle(1);
    wr_port(8'h03, 8'h02);
    rd_port(8'h03);
    wr_port(8'h03, 8'h02);
    wr_port(8'h04, 8'h00);
    idle(120);
    chk("int1_stopped", io.xINT1_P, 0);
    rd_port(8'h03);

    // unmapped port, constant-write strobe, strobe-less decode
    rd_port(8'h7F);
    step(0, 1, 0, 8'h02, 8'h03, 0, 8'h00);
    rd_port(8'h02);
    rx_push(8'h77);
    peek = 1;
    step(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    peek = 0;
    rd_port(8'h00);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic rxv;
      txr = 1'($urandom_range(0, 1));
      rxv = ($urandom_range(0, 2) == 0);
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: step(1, 0, 0, 8'h00, 8'($urandom), rxv, 8'($urandom));
        3, 4:    step(0, 0, 1, 8'h00, 8'h00, rxv, 8'($urandom));
        5:       step(0, 0, 1, 8'h01, 8'h00, rxv, 8'($urandom));
        6:       step(1, 0, 1, 8'h00, 8'($urandom), rxv, 8'($urandom));
        7:       step(0, 0, 1, 8'h03, 8'h00, rxv, 8'($urandom));
        8:       step(0, 1, 0, 8'h03, 8'($urandom_range(0, 15)), rxv, 8'($urandom));
        default: if ($urandom_range(0, 1) == 1)
                   step(1, 0, 0, 8'h04, 8'($urandom_range(0, 2)), rxv, 8'($urandom));
                 else
                   step(1, 0, 0, 8'h02, 8'($urandom_range(0, 3)), rxv, 8'($urandom));
      endcase
    end

    txr = 1;
    idle(12);
    chk("tx_final_drain", tx_q.size(), 0);
    mon_en = 0;
    chk("read_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
